pipe_position_ctrl: RTL and testbench
=====================================

Name: pipe_position_ctrl

Overview:
Game-flow controller for a side-scrolling pipe game. It owns the three-state game FSM (idle/play/over) and the horizontal position and vertical gap of a single scrolling pipe. Pipe geometry goes to the renderer and to a combinational collision checker; that checker's `collided` result is fed back into this block. `enable` is the frame/step strobe from the timing block.

Parameters:
- SCREEN_W, 640: pipe x reload value after wrap and after reset.
- PIPE_SPEED, 4: pixels pipe_x decreases per enabled step.
- GAP, 120: vertical opening, pipe_y_bot − pipe_y_top.
- GAP_TOP_INIT, 200: pipe_y_top after reset.
- GAP_TOP_MIN, 40: offset added to the random gap draw.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_button  in  1  start/restart request, level-sampled each clk.
- bird_y  in  10  bird top-edge y in pixels; range-checked for floor/ceiling loss.
- collided  in  1  combinational bird/pipe overlap flag.
- enable  in  1  step qualifier; pipe advances on every clk where enable=1.
- pipe_x  out  10  pipe left edge x.
- pipe_y_top  out  10  bottom edge of the top pipe segment.
- pipe_y_bot  out  10  top edge of the bottom pipe segment.
- led1  out  1  1 when state = IDLE.
- led2  out  1  1 when state = PLAY.
- led3  out  1  1 when state = OVER.
- state  out  2  FSM state: IDLE=0, PLAY=1, OVER=2; 3 unused.

Behaviour:
- Reset values: state=IDLE, pipe_x=SCREEN_W, pipe_y_top=GAP_TOP_INIT, pipe_y_bot=GAP_TOP_INIT+GAP, led1=1, led2=0, led3=0.
- All outputs are registered; LEDs decode directly from the state register.
- IDLE:
  - start_button=1 → PLAY on the next clk.
  - Pipe is held at its reset values.
- PLAY:
  - Loss condition: collided=1, or bird_y < 4, or bird_y > 460. Loss → OVER on the next clk; pipe does not move that cycle.
  - Otherwise, if enable=1:
    - pipe_x > PIPE_SPEED: pipe_x ← pipe_x − PIPE_SPEED.
    - pipe_x ≤ PIPE_SPEED (wrap): pipe_x ← SCREEN_W and a new gap is loaded.
  - enable=0 → pipe holds.
  - start_button is ignored.
- OVER:
  - Pipe frozen.
  - start_button=1 → IDLE; pipe reloads reset values.
- Illegal state 3 → IDLE on the next clk.
- Invariant: pipe_y_bot = pipe_y_top + GAP at all times. All arithmetic is 10-bit unsigned; no underflow is possible because of the wrap rule.
- Simultaneous events:
  - collided and wrap in the same cycle: loss wins, pipe does not update.
  - Reset mid-game: immediate return to reset values.

Optional Feature:
- Macro: RANDOM_GAP_EN.
- When defined:
  - An 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances every clk.
  - On wrap, pipe_y_top ← GAP_TOP_MIN + lfsr, giving 40..295, so pipe_y_bot ≤ 415.
- When undefined:
  - No LFSR is built.
  - The gap stays at GAP_TOP_INIT forever.

Decomposition:
- Shared package pipe_game_pkg holds:
  - the state enum (IDLE/PLAY/OVER);
  - SCREEN_W, SCREEN_H=480, PIPE_W=50, BIRD_W=20, BIRD_H=20, BIRD_X=100.
- Natural sub-module pipe_gap_lfsr: the LFSR and gap draw, instantiated only under RANDOM_GAP_EN.
- The collision checker is a separate combinational block.
  - Inputs: bird_x/y/width/height, pipe_x, pipe_width, pipe_height, pipe_y_top, pipe_y_bot.
  - collided = x-overlap AND (bird_y < pipe_y_top OR bird_y+bird_height > pipe_y_bot).
  - x-overlap: bird_x < pipe_x+pipe_width AND bird_x+bird_width > pipe_x.
  - pipe_height is unused and kept for interface compatibility.
  - It sits outside this block and drives `collided`.

Test Plan:
1. Reset asserted asynchronously mid-cycle → state=0, led1=1, pipe_x=640, pipe_y_top=200, pipe_y_bot=320, immediately.
2. Release reset, pulse start_button for 1 clk → state=1 and led2=1 on the next clk. With enable high for 2 clks, pipe_x=632.
3. PLAY with bird_y=250, bird_x=100 (wired checker), enable held high → pipe_x steps by 4 per clk. No loss while the pipe crosses x≈50..120, since bird 250..270 is inside gap 200..320. Pipe_x 4 → 640 on the next enabled clk.
4. PLAY, force collided=1 for 1 clk → state=2, led3=1; pipe_x frozen thereafter despite enable toggling.
5. OVER, pulse start_button → state=0, pipe_x=640; a second start pulse → PLAY.
6. RANDOM_GAP_EN defined, run through 3 wraps → each new pipe_y_top is in 40..295 and pipe_y_bot − pipe_y_top = 120. Undefined → pipe_y_top stays 200.

Source files
------------

// File: rtl/pipe_game_pkg.sv
// Shared definitions for the pipe game: FSM state encoding, screen and
// sprite geometry, and the bird vertical bounds used for floor/ceiling loss.
package pipe_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PIPE_W   = 50;
  localparam int unsigned BIRD_W   = 20;
  localparam int unsigned BIRD_H   = 20;
  localparam int unsigned BIRD_X   = 100;

  // Bird top edge must stay within [BIRD_Y_MIN, BIRD_Y_MAX] to keep playing.
  localparam logic [9:0] BIRD_Y_MIN = 10'd4;
  localparam logic [9:0] BIRD_Y_MAX = 10'd460;

  // True when the bird has touched the ceiling or the floor.
  function automatic logic bird_out_of_bounds(input logic [9:0] y);
    return (y < BIRD_Y_MIN) || (y > BIRD_Y_MAX);
  endfunction

endpackage

// File: rtl/pipe_gap_lfsr.sv
// Random gap source: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded with
// 8'hA5, stepping every clock. The gap draw is GAP_TOP_MIN + lfsr, which
// keeps the top of the opening in GAP_TOP_MIN..GAP_TOP_MIN+255.
// Only instantiated when RANDOM_GAP_EN is defined.
module pipe_gap_lfsr #(
  parameter int unsigned GAP_TOP_MIN = 40
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] gap_top
);

  localparam logic [7:0] SEED      = 8'hA5;
  localparam logic [9:0] GAP_MIN_V = 10'(GAP_TOP_MIN);

  logic [7:0] lfsr;
  logic       feedback;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  always_comb begin
    feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Free-running LFSR; reseeded on reset so the gap sequence is repeatable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

  // Candidate gap top offered to the controller on every pipe wrap.
  always_comb begin
    gap_top = GAP_MIN_V + {2'b00, lfsr};
  end

endmodule

// File: rtl/pipe_position_ctrl.sv
// Game-flow controller: IDLE/PLAY/OVER FSM plus position and gap of the
// single scrolling pipe. All outputs are registered.
// Optional feature macro: RANDOM_GAP_EN (random gap reload on pipe wrap);
// without it the gap stays at GAP_TOP_INIT.
module pipe_position_ctrl
  import pipe_game_pkg::*;
#(
  parameter int unsigned SCREEN_W     = pipe_game_pkg::SCREEN_W,
  parameter int unsigned PIPE_SPEED   = 4,
  parameter int unsigned GAP          = 120,
  parameter int unsigned GAP_TOP_INIT = 200
`ifdef RANDOM_GAP_EN
  ,
  parameter int unsigned GAP_TOP_MIN  = 40
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic [9:0] bird_y,
  input  logic       collided,
  input  logic       enable,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] state
);

  localparam logic [9:0] SCREEN_X   = 10'(SCREEN_W);
  localparam logic [9:0] SPEED_V    = 10'(PIPE_SPEED);
  localparam logic [9:0] GAP_V      = 10'(GAP);
  localparam logic [9:0] GAP_INIT_V = 10'(GAP_TOP_INIT);

  logic [1:0] state_nxt;
  logic [9:0] pipe_x_nxt;
  logic [9:0] pipe_y_top_nxt;
  logic [9:0] pipe_y_bot_nxt;
  logic       led1_nxt;
  logic       led2_nxt;
  logic       led3_nxt;
  logic       loss;
  logic [9:0] gap_draw;

`ifdef RANDOM_GAP_EN
  pipe_gap_lfsr #(
    .GAP_TOP_MIN (GAP_TOP_MIN)
  ) u_gap_lfsr (
    .clk     (clk),
    .reset   (reset),
    .gap_top (gap_draw)
  );
`else
  // Fixed gap: every wrap reloads the initial opening.
  always_comb begin
    gap_draw = GAP_INIT_V;
  end
`endif

  // Loss: overlap reported by the collision checker, or ceiling/floor hit.
  always_comb begin
    loss = collided || bird_out_of_bounds(bird_y);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is ignored while playing, encoding 3 recovers to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_button) begin
          state_nxt = PLAY;
        end else begin
          state_nxt = IDLE;
        end
      end
      PLAY: begin
        if (loss) begin
          state_nxt = OVER;
        end else begin
          state_nxt = PLAY;
        end
      end
      OVER: begin
        if (start_button) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pipe motion and LED values for the upcoming state.
  always_comb begin
    pipe_x_nxt     = pipe_x;
    pipe_y_top_nxt = pipe_y_top;
    case (state)
      IDLE: begin
        pipe_x_nxt     = SCREEN_X;
        pipe_y_top_nxt = GAP_INIT_V;
      end
      PLAY: begin
        // A losing cycle freezes the pipe, even if it would have wrapped.
        if (!loss && enable) begin
          if (pipe_x > SPEED_V) begin
            pipe_x_nxt = pipe_x - SPEED_V;
          end else begin
            pipe_x_nxt     = SCREEN_X;
            pipe_y_top_nxt = gap_draw;
          end
        end else begin
          pipe_x_nxt     = pipe_x;
          pipe_y_top_nxt = pipe_y_top;
        end
      end
      OVER: begin
        if (start_button) begin
          pipe_x_nxt     = SCREEN_X;
          pipe_y_top_nxt = GAP_INIT_V;
        end else begin
          pipe_x_nxt     = pipe_x;
          pipe_y_top_nxt = pipe_y_top;
        end
      end
      default: begin
        pipe_x_nxt     = SCREEN_X;
        pipe_y_top_nxt = GAP_INIT_V;
      end
    endcase
    pipe_y_bot_nxt = pipe_y_top_nxt + GAP_V;
    led1_nxt       = (state_nxt == IDLE);
    led2_nxt       = (state_nxt == PLAY);
    led3_nxt       = (state_nxt == OVER);
  end

  // Output registers for pipe geometry and LEDs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_x     <= SCREEN_X;
      pipe_y_top <= GAP_INIT_V;
      pipe_y_bot <= GAP_INIT_V + GAP_V;
      led1       <= 1'b1;
      led2       <= 1'b0;
      led3       <= 1'b0;
    end else begin
      pipe_x     <= pipe_x_nxt;
      pipe_y_top <= pipe_y_top_nxt;
      pipe_y_bot <= pipe_y_bot_nxt;
      led1       <= led1_nxt;
      led2       <= led2_nxt;
      led3       <= led3_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_position_ctrl.sv
// Scoreboard bench for pipe_position_ctrl: stimulus pushes the reference
// model's expected outputs per clock, a monitor pops and compares them.
// The external collision checker is modelled here and wired to the DUT.
module tb_pipe_position_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_button;
  logic [9:0] bird_y;
  logic       collided;
  logic       enable;
  logic [9:0] pipe_x;
  logic [9:0] pipe_y_top;
  logic [9:0] pipe_y_bot;
  logic       led1;
  logic       led2;
  logic       led3;
  logic [1:0] state;

  pipe_position_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start_button (start_button),
    .bird_y       (bird_y),
    .collided     (collided),
    .enable       (enable),
    .pipe_x       (pipe_x),
    .pipe_y_top   (pipe_y_top),
    .pipe_y_bot   (pipe_y_bot),
    .led1         (led1),
    .led2         (led2),
    .led3         (led3),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int x;
    int top;
    bit top_known;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: game state 0/1/2, pipe x and gap top as integers.
  int m_st;
  int m_x;
  int m_top;
  bit m_top_known;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk("state", int'(state), e.st);
    chk("led1", int'(led1), int'(e.st == 0));
    chk("led2", int'(led2), int'(e.st == 1));
    chk("led3", int'(led3), int'(e.st == 2));
    chk("pipe_x", int'(pipe_x), e.x);
    if (e.top_known) begin
      chk("pipe_y_top", int'(pipe_y_top), e.top);
      chk("pipe_y_bot", int'(pipe_y_bot), e.top + 120);
    end else begin
      chk("gap_range", int'(pipe_y_top >= 10'd40 && pipe_y_top <= 10'd295), 1);
      chk("gap_width", int'(pipe_y_bot) - int'(pipe_y_top), 120);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_x = 640;
    m_top = 200;
    m_top_known = 1'b1;
  endtask

  // Game rules applied to one clock with the given inputs.
  task automatic model_step(input bit st_b, input int by, input bit col, input bit en);
    bit lost;
    lost = col || (by < 4) || (by > 460);
    case (m_st)
      0: if (st_b) m_st = 1;
      1: begin
        if (lost) m_st = 2;
        else if (en) begin
          if (m_x > 4) m_x = m_x - 4;
          else begin
            m_x = 640;
`ifdef RANDOM_GAP_EN
            m_top_known = 1'b0;
`else
            m_top = 200;
`endif
          end
        end
      end
      2: if (st_b) model_reset();
      default: model_reset();
    endcase
    sb.push_back('{m_st, m_x, m_top, m_top_known});
  endtask

  // Behaviour of the external collision checker (bird at x=100, 20x20, pipe 50 wide).
  function automatic bit wired_collision(input int by, input int px, input int top, input int bot);
    bit xo;
    xo = (100 < px + 50) && (100 + 20 > px);
    return xo && ((by < top) || (by + 20 > bot));
  endfunction

  task automatic step(input bit st_b, input int by, input bit force_col, input bit en);
    @(negedge clk);
    start_button = st_b;
    bird_y = 10'(by);
    enable = en;
    collided = force_col | wired_collision(by, int'(pipe_x), int'(pipe_y_top), int'(pipe_y_bot));
    model_step(st_b, by, collided, en);
  endtask

  task automatic check_reset_values();
    chk("rst_state", int'(state), 0);
    chk("rst_led1", int'(led1), 1);
    chk("rst_led2", int'(led2), 0);
    chk("rst_led3", int'(led3), 0);
    chk("rst_pipe_x", int'(pipe_x), 640);
    chk("rst_pipe_y_top", int'(pipe_y_top), 200);
    chk("rst_pipe_y_bot", int'(pipe_y_bot), 320);
  endtask

  // Monitor: compare after every active edge whenever an expectation is queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs(e);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start_button = 1'b0;
    bird_y = 10'd250;
    collided = 1'b0;
    enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // Start, then two enabled steps: 640 -> 636 -> 632.
    step(1'b1, 250, 1'b0, 1'b0);
    step(1'b0, 250, 1'b0, 1'b1);
    step(1'b0, 250, 1'b0, 1'b1);
    // Cross the bird column and wrap (4 -> 640) with the bird inside the gap.
    repeat (170) step(1'b0, 250, 1'b0, 1'b1);
    // Start ignored while playing.
    step(1'b1, 250, 1'b0, 1'b1);
    // Forced collision, then pipe frozen while enable toggles.
    step(1'b0, 250, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 250, 1'b0, 1'(i % 2));
    // Restart to IDLE, idle a cycle, start again.
    step(1'b1, 250, 1'b0, 1'b1);
    step(1'b0, 250, 1'b0, 1'b1);
    step(1'b1, 250, 1'b0, 1'b1);
    // Bounds: 4 and 460 are safe, 461 loses.
    step(1'b0, 4, 1'b0, 1'b1);
    step(1'b0, 460, 1'b0, 1'b1);
    step(1'b0, 461, 1'b0, 1'b1);
    step(1'b1, 250, 1'b0, 1'b0);
    step(1'b1, 250, 1'b0, 1'b1);
    step(1'b0, 3, 1'b0, 1'b1);
    // Back to PLAY, move a bit, then asynchronous reset mid-cycle.
    step(1'b1, 250, 1'b0, 1'b0);
    step(1'b1, 250, 1'b0, 1'b0);
    repeat (5) step(1'b0, 250, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized play.
    for (int n = 0; n < 4000; n++) begin
      bit st_b;
      bit fc;
      bit en;
      int r;
      int by;
      st_b = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 1999);
      if (r == 0) by = $urandom_range(0, 3);
      else if (r == 1) by = $urandom_range(461, 1023);
      else by = $urandom_range(210, 295);
      fc = ($urandom_range(0, 1499) == 0);
      en = ($urandom_range(0, 3) != 0);
      step(st_b, by, fc, en);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
